seq_arb_4in_req_queue: RTL and testbench

Four-lane request buffer that sits directly upstream of the 4-input rotating arbiter. Each lane holds a 4-entry FIFO of messages from one requester and drives one bit of the arbiter's `reqs` vector. The arbiter's one-hot `grants` vector selects a lane; that lane's head message is dequeued and presented on a single output port in the same cycle. Arbitration policy lives entirely in the arbiter; this block only buffers, requests, and muxes.

---
 rtl/seq_arb_4in_req_queue_if.sv | 28 ++
 rtl/seq_arb_4in_req_queue.sv | 81 ++++++++
 tb/tb_seq_arb_4in_req_queue.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_arb_4in_req_queue_if.sv
// Bundle of the four-lane enqueue side, the arbiter request/grant pair and the
// single dequeue port of seq_arb_4in_req_queue.
interface seq_arb_4in_req_queue_if #(
  parameter int p_nbits = 8
);
  logic [3:0]         in_val;
  logic [3:0]         in_rdy;
  logic [p_nbits-1:0] in_msg0;
  logic [p_nbits-1:0] in_msg1;
  logic [p_nbits-1:0] in_msg2;
  logic [p_nbits-1:0] in_msg3;
  logic [3:0]         reqs;
  logic [3:0]         grants;
  logic               out_val;
  logic [p_nbits-1:0] out_msg;

  // Environment side: requesters, arbiter and output consumer.
  modport master (
    output in_val, in_msg0, in_msg1, in_msg2, in_msg3, grants,
    input  in_rdy, reqs, out_val, out_msg
  );

  // Queue side.
  modport slave (
    input  in_val, in_msg0, in_msg1, in_msg2, in_msg3, grants,
    output in_rdy, reqs, out_val, out_msg
  );
endinterface

// File: rtl/seq_arb_4in_req_queue.sv
// Four independent 4-deep lane FIFOs feeding an external rotating arbiter; the
// granted lane's head is popped and shown on the single output port in the same cycle.
module seq_arb_4in_req_queue #(
  parameter int p_nbits = 8
) (
  input logic                    clk,
  input logic                    reset,
  seq_arb_4in_req_queue_if.slave bus
);

  logic [3:0][p_nbits-1:0] in_msg_all;
  logic [3:0][p_nbits-1:0] head_msg;
  logic [3:0]              count_nz;
  logic [3:0]              enq;
  logic [3:0]              deq;
  logic [3:0]              sel;
  logic                    sel_onehot;

  assign in_msg_all = {bus.in_msg3, bus.in_msg2, bus.in_msg1, bus.in_msg0};

  // Requests come only from registered state, so the arbiter loop stays acyclic.
  assign bus.reqs   = count_nz;
  assign sel        = bus.grants & count_nz;
  assign sel_onehot = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign deq        = sel_onehot ? sel : 4'd0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [1:0]         head_q, head_d;
      logic [1:0]         tail_q, tail_d;
      logic [2:0]         count_q, count_d;
      logic [p_nbits-1:0] mem_q [4];

      assign count_nz[gi]   = (count_q != 3'd0);
      assign bus.in_rdy[gi] = (count_q != 3'd4);
      assign enq[gi]        = bus.in_val[gi] && (count_q != 3'd4);
      assign head_msg[gi]   = mem_q[head_q];

      always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq[gi]) head_d = head_q + 2'd1;
        if (enq[gi]) tail_d = tail_q + 2'd1;
        case ({enq[gi], deq[gi]})
          2'b10:   count_d = count_q + 3'd1;
          2'b01:   count_d = count_q - 3'd1;
          default: count_d = count_q;
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          head_q  <= 2'd0;
          tail_q  <= 2'd0;
          count_q <= 3'd0;
        end else begin
          head_q  <= head_d;
          tail_q  <= tail_d;
          count_q <= count_d;
        end
      end

      // Storage is never cleared; stale entries are unreachable once count is 0.
      always_ff @(posedge clk) begin
        if (!reset && enq[gi]) mem_q[tail_q] <= in_msg_all[gi];
      end
    end
  endgenerate

  always_comb begin
    bus.out_msg = '0;
    for (int i = 0; i < 4; i++) begin
      if (deq[i]) bus.out_msg = head_msg[i];
    end
  end

  assign bus.out_val = |deq;

endmodule

// File: tb/tb_seq_arb_4in_req_queue.sv
// Directed self-checking bench for seq_arb_4in_req_queue: one task per scenario,
// expected values written out by hand or computed from the message numbering.
module tb_seq_arb_4in_req_queue;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  seq_arb_4in_req_queue_if #(.p_nbits(8)) bus ();

  seq_arb_4in_req_queue #(.p_nbits(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_val  = 4'b0000;
    bus.in_msg0 = 8'h00;
    bus.in_msg1 = 8'h00;
    bus.in_msg2 = 8'h00;
    bus.in_msg3 = 8'h00;
    bus.grants  = 4'b0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    #1;
    n_total++;
    if (bus.reqs !== 4'b0000) $display("FAIL reset_reqs got %b want 0000", bus.reqs);
    else n_pass++;
    n_total++;
    if (bus.in_rdy !== 4'b1111) $display("FAIL reset_in_rdy got %b want 1111", bus.in_rdy);
    else n_pass++;
    n_total++;
    if (bus.out_val !== 1'b0 || bus.out_msg !== 8'h00)
      $display("FAIL reset_out got val=%b msg=%h want val=0 msg=00", bus.out_val, bus.out_msg);
    else n_pass++;
    reset = 1'b0;
    tick();
    bus.grants = 4'b0001;
    #1;
    n_total++;
    if (bus.out_val !== 1'b0) $display("FAIL empty_grant_out_val got %b want 0", bus.out_val);
    else n_pass++;
    $display("reset: reqs=%b in_rdy=%b", bus.reqs, bus.in_rdy);
    idle_inputs();
  endtask

  task automatic test_single();
    bus.in_val  = 4'b0001;
    bus.in_msg0 = 8'hA5;
    #1;
    n_total++;
    if (bus.reqs !== 4'b0000) $display("FAIL single_no_bypass got %b want 0000", bus.reqs);
    else n_pass++;
    tick();
    idle_inputs();
    bus.grants = 4'b0001;
    #1;
    n_total++;
    if (bus.reqs !== 4'b0001) $display("FAIL single_reqs got %b want 0001", bus.reqs);
    else n_pass++;
    n_total++;
    if (bus.out_val !== 1'b1 || bus.out_msg !== 8'hA5)
      $display("FAIL single_out got val=%b msg=%h want val=1 msg=a5", bus.out_val, bus.out_msg);
    else n_pass++;
    $display("single: deq msg=%h", bus.out_msg);
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (bus.reqs !== 4'b0000) $display("FAIL single_reqs_after got %b want 0000", bus.reqs);
    else n_pass++;
  endtask

  task automatic drain_lane2(input logic [7:0] first, input string tag);
    for (int k = 0; k < 4; k++) begin
      bus.grants = 4'b0100;
      #1;
      n_total++;
      if (bus.out_val !== 1'b1 || bus.out_msg !== first + 8'(k))
        $display("FAIL %s_%0d got val=%b msg=%h want val=1 msg=%h",
                 tag, k, bus.out_val, bus.out_msg, first + 8'(k));
      else n_pass++;
      $display("%s: deq lane2 msg=%h", tag, bus.out_msg);
      tick();
    end
    idle_inputs();
    #1;
    n_total++;
    if (bus.reqs[2] !== 1'b0) $display("FAIL %s_empty got reqs=%b want reqs[2]=0", tag, bus.reqs);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    for (int k = 0; k < 4; k++) begin
      bus.in_val  = 4'b0100;
      bus.in_msg2 = 8'h10 + 8'(k);
      tick();
    end
    idle_inputs();
    #1;
    n_total++;
    if (bus.in_rdy !== 4'b1011) $display("FAIL full_in_rdy got %b want 1011", bus.in_rdy);
    else n_pass++;
    bus.in_val  = 4'b0100;
    bus.in_msg2 = 8'h14;
    tick();
    idle_inputs();
    drain_lane2(8'h10, "order");
    for (int k = 0; k < 4; k++) begin
      bus.in_val  = 4'b0100;
      bus.in_msg2 = 8'h40 + 8'(k);
      tick();
    end
    idle_inputs();
    drain_lane2(8'h40, "wrap");
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 3; k++) begin
      bus.in_val  = 4'b0010;
      bus.in_msg1 = 8'h1A + 8'(k);
      tick();
    end
    bus.in_val  = 4'b0010;
    bus.in_msg1 = 8'h20;
    bus.grants  = 4'b0010;
    #1;
    n_total++;
    if (bus.out_val !== 1'b1 || bus.out_msg !== 8'h1A)
      $display("FAIL simul_c3_out got val=%b msg=%h want val=1 msg=1a", bus.out_val, bus.out_msg);
    else n_pass++;
    $display("simul: push 20 + deq msg=%h", bus.out_msg);
    tick();
    // One more push only brings the lane to full if the count stayed at 3.
    idle_inputs();
    bus.in_val  = 4'b0010;
    bus.in_msg1 = 8'h21;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (bus.in_rdy[1] !== 1'b0) $display("FAIL simul_c3_count got in_rdy=%b want in_rdy[1]=0", bus.in_rdy);
    else n_pass++;
    bus.in_val  = 4'b0010;
    bus.in_msg1 = 8'h22;
    bus.grants  = 4'b0010;
    #1;
    n_total++;
    if (bus.out_val !== 1'b1 || bus.out_msg !== 8'h1B)
      $display("FAIL simul_c4_out got val=%b msg=%h want val=1 msg=1b", bus.out_val, bus.out_msg);
    else n_pass++;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (bus.in_rdy[1] !== 1'b1) $display("FAIL simul_c4_count got in_rdy=%b want in_rdy[1]=1", bus.in_rdy);
    else n_pass++;
    begin
      logic [7:0] exp_seq [3];
      exp_seq[0] = 8'h1C;
      exp_seq[1] = 8'h20;
      exp_seq[2] = 8'h21;
      for (int k = 0; k < 3; k++) begin
        bus.grants = 4'b0010;
        #1;
        n_total++;
        if (bus.out_val !== 1'b1 || bus.out_msg !== exp_seq[k])
          $display("FAIL simul_drain_%0d got val=%b msg=%h want val=1 msg=%h",
                   k, bus.out_val, bus.out_msg, exp_seq[k]);
        else n_pass++;
        $display("simul: deq lane1 msg=%h", bus.out_msg);
        tick();
      end
    end
    idle_inputs();
    #1;
    n_total++;
    if (bus.reqs !== 4'b0000) $display("FAIL simul_empty got reqs=%b want 0000", bus.reqs);
    else n_pass++;
  endtask

  task automatic test_four_lane();
    for (int k = 0; k < 2; k++) begin
      bus.in_val  = 4'b1111;
      bus.in_msg0 = 8'h00 + 8'(k);
      bus.in_msg1 = 8'h10 + 8'(k);
      bus.in_msg2 = 8'h20 + 8'(k);
      bus.in_msg3 = 8'h30 + 8'(k);
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] exp_msg;
      exp_msg = {4'(k % 4), 4'(k / 4)};
      if (k == 2) begin
        bus.grants = 4'b0011;
        #1;
        n_total++;
        if (bus.out_val !== 1'b0 || bus.out_msg !== 8'h00)
          $display("FAIL illegal_grant got val=%b msg=%h want val=0 msg=00", bus.out_val, bus.out_msg);
        else n_pass++;
        $display("rr: illegal grant 0011 ignored");
        tick();
      end
      bus.grants = 4'b0001 << (k % 4);
      #1;
      n_total++;
      if (bus.out_val !== 1'b1 || bus.out_msg !== exp_msg)
        $display("FAIL rr_%0d got val=%b msg=%h want val=1 msg=%h", k, bus.out_val, bus.out_msg, exp_msg);
      else n_pass++;
      $display("rr: grant=%b deq msg=%h", bus.grants, bus.out_msg);
      tick();
    end
    idle_inputs();
    #1;
    n_total++;
    if (bus.reqs !== 4'b0000) $display("FAIL rr_empty got reqs=%b want 0000", bus.reqs);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      bus.in_val  = 4'b1111;
      bus.in_msg0 = 8'h50 + 8'(k);
      bus.in_msg1 = 8'h60 + 8'(k);
      bus.in_msg2 = 8'h70 + 8'(k);
      bus.in_msg3 = 8'h80 + 8'(k);
      tick();
    end
    reset       = 1'b1;
    bus.in_val  = 4'b1111;
    bus.in_msg3 = 8'h99;
    bus.grants  = 4'b0001;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    n_total++;
    if (bus.reqs !== 4'b0000) $display("FAIL midrst_reqs got %b want 0000", bus.reqs);
    else n_pass++;
    n_total++;
    if (bus.in_rdy !== 4'b1111) $display("FAIL midrst_in_rdy got %b want 1111", bus.in_rdy);
    else n_pass++;
    $display("midrst: reqs=%b in_rdy=%b", bus.reqs, bus.in_rdy);
    bus.in_val  = 4'b1000;
    bus.in_msg3 = 8'h77;
    tick();
    idle_inputs();
    bus.grants = 4'b1000;
    #1;
    n_total++;
    if (bus.out_val !== 1'b1 || bus.out_msg !== 8'h77)
      $display("FAIL midrst_first got val=%b msg=%h want val=1 msg=77", bus.out_val, bus.out_msg);
    else n_pass++;
    $display("midrst: deq lane3 msg=%h", bus.out_msg);
    tick();
    idle_inputs();
    #1;
    n_total++;
    if (bus.reqs !== 4'b0000) $display("FAIL midrst_empty got reqs=%b want 0000", bus.reqs);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_full_wrap();
    test_simultaneous();
    test_four_lane();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
